his_acq_scheduler: RTL

Sequences one two-pass dToF acquisition through the shared histogram builder (`hisBuilderFSM`). The first pass is a coarse histogram (CH) over a fixed number of laser cycles. The scheduler then hands off to the peak detector and collects one coarse peak bin per pixel. The second pass is a fine histogram (FH) that forwards only timestamps inside each pixel's peak window. It sits between the TDC timestamp stream and the histogram builder, and owns `wrEn`, `hisNum` and `acq_count_finish` for the whole acquisition.

---
 rtl/his_acq_scheduler.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/his_acq_scheduler.sv
// rtl/his_acq_scheduler.sv - two-pass (coarse/fine) dToF acquisition sequencer for the shared histogram builder
module his_acq_scheduler #(
  parameter int NP        = 10,
  parameter int NB        = 5,
  parameter int PIXEL_NUM = 3,
  parameter int PW        = 2,
  parameter int CYCLES_CH = 4,
  parameter int CYCLES_FH = 4
) (
  input  logic          clk,
  input  logic          res,
  input  logic          start,
  input  logic          laser_sync,
  input  logic          ts_valid,
  input  logic [NP-1:0] ts_data,
  input  logic [PW-1:0] ts_pixel,
  output logic          ts_ready,
  output logic          wrEn,
  output logic [NP-1:0] data,
  output logic [PW-1:0] pixel,
  output logic          hisNum,
  output logic          acq_count_finish,
  input  logic          peakDone,
  input  logic [PW-1:0] peak_pixel,
  input  logic [NB-1:0] peakCH,
  output logic          busy,
  output logic          done,
  output logic [15:0]   drop_cnt
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CH_ACQ    = 3'd1;
  localparam logic [2:0] S_CH_END    = 3'd2;
  localparam logic [2:0] S_PEAK_WAIT = 3'd3;
  localparam logic [2:0] S_FH_ACQ    = 3'd4;
  localparam logic [2:0] S_FH_END    = 3'd5;

  // Counter only ever needs to reach (cycles - 1) of the longer pass.
  localparam int CMAX = (CYCLES_CH > CYCLES_FH) ? CYCLES_CH : CYCLES_FH;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] LAST_CH = CW'(CYCLES_CH - 1);
  localparam logic [CW-1:0] LAST_FH = CW'(CYCLES_FH - 1);
  // One extra bit so PIXEL_NUM == 2**PW still compares correctly.
  localparam logic [PW:0]   PIX_LIM = (PW+1)'(PIXEL_NUM);

  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [PIXEL_NUM-1:0] mask_q, mask_d;
  logic [15:0]          drop_q, drop_d;
  logic                 his_q, his_d;
  logic [NB-1:0]        peak_q [PIXEL_NUM];
  logic                 wr_q;
  logic [NP-1:0]        data_q;
  logic [PW-1:0]        pixel_q;

  logic                 in_ch, in_fh, accept, pix_ok, win_hit, fwd, drop;
  logic                 peak_ok;
  logic [PIXEL_NUM-1:0] peak_hot;
  logic [NB-1:0]        sel_peak;

  assign in_ch    = (state_q == S_CH_ACQ);
  assign in_fh    = (state_q == S_FH_ACQ);
  assign ts_ready = in_ch | in_fh;
  assign accept   = ts_valid & ts_ready;
  assign pix_ok   = ({1'b0, ts_pixel} < PIX_LIM);
  assign win_hit  = (ts_data[NP-1:NP-NB] == sel_peak);
  // Coarse pass keeps every valid-pixel timestamp; fine pass only in-window ones.
  assign fwd      = accept & pix_ok & (in_ch | win_hit);
  assign drop     = accept & in_fh & ~fwd;
  assign peak_ok  = peakDone & (state_q == S_PEAK_WAIT) & ({1'b0, peak_pixel} < PIX_LIM);

  // Peak bin of the timestamp's pixel and one-hot of the reporting pixel.
  always_comb begin
    sel_peak = '0;
    peak_hot = '0;
    for (int i = 0; i < PIXEL_NUM; i++) begin
      if (ts_pixel == PW'(i)) sel_peak = peak_q[i];
      if (peak_pixel == PW'(i)) peak_hot[i] = 1'b1;
    end
  end

  // Pass sequencing, laser-cycle counting, peak mask and drop accounting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    drop_d  = drop_q;
    his_d   = his_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CH_ACQ;
          cnt_d   = '0;
          mask_d  = '0;
          drop_d  = '0;
          his_d   = 1'b0;
        end
      end
      S_CH_ACQ: begin
        if (laser_sync) begin
          if (cnt_q == LAST_CH) state_d = S_CH_END;
          else                  cnt_d   = cnt_q + 1'b1;
        end
      end
      S_CH_END: state_d = S_PEAK_WAIT;
      S_PEAK_WAIT: begin
        if (peak_ok) mask_d = mask_q | peak_hot;
        if (&mask_d) begin
          state_d = S_FH_ACQ;
          his_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      S_FH_ACQ: begin
        if (laser_sync) begin
          if (cnt_q == LAST_FH) state_d = S_FH_END;
          else                  cnt_d   = cnt_q + 1'b1;
        end
      end
      S_FH_END: begin
        state_d = S_IDLE;
        his_d   = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
    if (drop && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  // Control state registers.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
      drop_q  <= '0;
      his_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      drop_q  <= drop_d;
      his_q   <= his_d;
    end
  end

  // Per-pixel coarse peak bins; a repeated report simply overwrites.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      for (int i = 0; i < PIXEL_NUM; i++) peak_q[i] <= '0;
    end else if (peak_ok) begin
      for (int i = 0; i < PIXEL_NUM; i++) begin
        if (peak_hot[i]) peak_q[i] <= peakCH;
      end
    end
  end

  // Registered builder write port, one strobe per forwarded timestamp.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      wr_q    <= 1'b0;
      data_q  <= '0;
      pixel_q <= '0;
    end else begin
      wr_q <= fwd;
      if (fwd) begin
        data_q  <= ts_data;
        pixel_q <= ts_pixel;
      end
    end
  end

  assign wrEn             = wr_q;
  assign data             = data_q;
  assign pixel            = pixel_q;
  assign hisNum           = his_q;
  assign acq_count_finish = (state_q == S_CH_END) | (state_q == S_FH_END);
  assign done             = (state_q == S_FH_END);
  assign busy             = (state_q != S_IDLE);
  assign drop_cnt         = drop_q;

endmodule
